// File: rtl/dmtd_phase_tagger.sv
// dmtd_phase_tagger: conditions the two DMTD beat signals and tags their
// rising edges, producing A->B phase and A->A period result pairs.

module dmtd_beat_edge #(
    parameter int DEGLITCH = 8,
    parameter int DG_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_i,
    output logic rise_o
);

    localparam logic [DG_W-1:0] DG_LAST = DG_W'(DEGLITCH - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            f_q;
    logic            f_d;
    logic            f_dly_q;
    logic [DG_W-1:0] dg_q;
    logic [DG_W-1:0] dg_d;

    // Two-flop synchronizer: the beat is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= beat_i;
            sync2_q <= sync1_q;
        end
    end

    // Filtered level flips only after DEGLITCH consecutive disagreeing samples.
    always_comb begin
        f_d  = f_q;
        dg_d = '0;
        if (sync2_q != f_q) begin
            if (dg_q == DG_LAST) begin
                f_d  = ~f_q;
                dg_d = '0;
            end else begin
                dg_d = dg_q + DG_W'(1);
            end
        end
    end

    // Filter state plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= 1'b0;
            dg_q    <= '0;
            f_dly_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            dg_q    <= dg_d;
            f_dly_q <= f_q;
        end
    end

    assign rise_o = f_q & ~f_dly_q;

endmodule

module dmtd_phase_tagger #(
    parameter int CNT_W    = 16,
    parameter int DEGLITCH = 8,
    parameter int DG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_a,
    input  logic             beat_b,
    input  logic             clr,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] phase_out,
    output logic [CNT_W-1:0] period_out,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tag_a_q;
    logic             have_prev_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             ovr_q;
    logic             ovr_d;
    logic             ovr_set;
    logic             ev_a;
    logic             ev_b;
    logic [CNT_W-1:0] a_period;

    dmtd_beat_edge #(
        .DEGLITCH (DEGLITCH),
        .DG_W     (DG_W)
    ) u_edge_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .beat_i (beat_a),
        .rise_o (ev_a)
    );

    dmtd_beat_edge #(
        .DEGLITCH (DEGLITCH),
        .DG_W     (DG_W)
    ) u_edge_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .beat_i (beat_b),
        .rise_o (ev_b)
    );

    // Spacing to the previous A edge; zero until a previous A edge exists.
    assign a_period = have_prev_q ? (tcnt_q - tag_a_q) : '0;

    // Free-running time base and A-edge tag history, updated on every A edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q      <= '0;
            tag_a_q     <= '0;
            have_prev_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_q + CNT_W'(1);
            if (ev_a) begin
                tag_a_q     <= tcnt_q;
                have_prev_q <= 1'b1;
            end
        end
    end

    // Measurement FSM: next state, result capture and overrun detection.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        period_d = period_q;
        ovr_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ev_a) begin
                    period_d = a_period;
                    if (ev_b) begin
                        phase_d = '0;
                        state_d = OUT;
                    end else begin
                        state_d = WAIT_B;
                    end
                end
            end
            WAIT_B: begin
                if (ev_b) begin
                    phase_d = tcnt_q - tag_a_q;
                    state_d = OUT;
                    ovr_set = ev_a;
                end else if (ev_a) begin
                    period_d = a_period;
                end
            end
            OUT: begin
                ovr_set = ev_a;
                if (ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ovr_d = ovr_set | (ovr_q & ~clr);
    end

    // Measurement state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            period_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            ovr_q    <= ovr_d;
        end
    end

    assign valid      = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign phase_out  = phase_q;
    assign period_out = period_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_dmtd_phase_tagger.sv
// tb_dmtd_phase_tagger: directed and randomized beat scenarios checked
// against expectations derived from edge timing arithmetic.

module tb_dmtd_phase_tagger;

    localparam int CW  = 16;
    localparam int D   = 8;
    localparam int DGW = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          beat_a = 1'b0;
    logic          beat_b = 1'b0;
    logic          clr    = 1'b0;
    logic          ready  = 1'b0;
    logic          valid;
    logic [CW-1:0] phase_out;
    logic [CW-1:0] period_out;
    logic          overrun;
    logic          busy;

    int n_tests   = 0;
    int n_fail    = 0;
    int since_rst = 0;

    always #5 clk = ~clk;

    dmtd_phase_tagger #(
        .CNT_W    (CW),
        .DEGLITCH (D),
        .DG_W     (DGW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_a     (beat_a),
        .beat_b     (beat_b),
        .clr        (clr),
        .ready      (ready),
        .valid      (valid),
        .phase_out  (phase_out),
        .period_out (period_out),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        since_rst++;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        beat_a = 1'b0;
        beat_b = 1'b0;
        clr    = 1'b0;
        ready  = 1'b0;
        repeat (3) tick();
        rst_n     = 1'b1;
        since_rst = 0;
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        check({tag, "_wait"}, 32'(valid), 32'd1);
    endtask

    initial begin
        int P;
        int L;
        int nres;
        int tmax;
        int n;
        int target;
        bit prev_xfer;
        bit saw;

        // reset state
        #2;
        do_reset();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_phase", 32'(phase_out), 32'd0);
        check("rst_period", 32'(period_out), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);

        // basic single measurement, B 100 cycles after A
        ready  = 1'b1;
        beat_a = 1'b1;
        repeat (100) tick();
        beat_b = 1'b1;
        wait_valid(D + 20, "basic");
        check("basic_phase", 32'(phase_out), 32'd100);
        check("basic_period", 32'(period_out), 32'd0);
        check("basic_ovr", 32'(overrun), 32'd0);
        tick();
        check("basic_drop", 32'(valid), 32'd0);
        beat_a = 1'b0;
        beat_b = 1'b0;
        repeat (D + 10) tick();

        // deglitch: D-1 cycle pulse rejected, D cycle pulse accepted
        do_reset();
        beat_a = 1'b1;
        repeat (D - 1) tick();
        beat_a = 1'b0;
        saw = 1'b0;
        repeat (3 * D) begin
            tick();
            if (busy || valid) saw = 1'b1;
        end
        check("short_pulse", 32'(saw), 32'd0);
        beat_a = 1'b1;
        for (int j = 1; j <= D + 3; j++) begin
            tick();
            if (j == D) beat_a = 1'b0;
            if (j == D + 2) check("dg_busy_early", 32'(busy), 32'd0);
            if (j == D + 3) check("dg_busy_rise", 32'(busy), 32'd1);
        end

        // periodic beats with random period and lag, consumer always ready
        do_reset();
        ready     = 1'b1;
        P         = $urandom_range(200, 600);
        L         = $urandom_range(1, P - 5);
        tmax      = 5 * P + L + D + 10;
        nres      = 0;
        prev_xfer = 1'b0;
        for (int t = 0; t < tmax; t++) begin
            beat_a = ((t % P) < (P / 2));
            beat_b = (t >= L) && (((t - L) % P) < (P / 2));
            tick();
            if (prev_xfer) check("per_drop", 32'(valid), 32'd0);
            prev_xfer = 1'b0;
            if (valid) begin
                check("per_phase", 32'(phase_out), 32'(L));
                check("per_period", 32'(period_out),
                      (nres == 0) ? 32'd0 : 32'(P));
                nres++;
                prev_xfer = 1'b1;
            end
        end
        check("per_count", 32'(nres), 32'd6);
        check("per_ovr", 32'(overrun), 32'd0);
        beat_a = 1'b0;
        beat_b = 1'b0;
        repeat (D + 10) tick();

        // stalled consumer: result held, overrun sets, clr clears it
        do_reset();
        ready = 1'b0;
        P     = $urandom_range(200, 400);
        L     = $urandom_range(10, P - 10);
        for (int t = 0; t < 2 * P + P / 2; t++) begin
            beat_a = ((t % P) < (P / 2));
            beat_b = (t >= L) && (((t - L) % P) < (P / 2));
            tick();
            if (t == L + D + 6) begin
                check("ovr_first_valid", 32'(valid), 32'd1);
                check("ovr_not_yet", 32'(overrun), 32'd0);
            end
        end
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_phase", 32'(phase_out), 32'(L));
        check("ovr_period", 32'(period_out), 32'd0);
        check("ovr_set", 32'(overrun), 32'd1);
        beat_a = 1'b0;
        beat_b = 1'b0;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        check("ovr_hold_valid", 32'(valid), 32'd1);
        check("ovr_hold_phase", 32'(phase_out), 32'(L));
        ready = 1'b1;
        tick();
        check("ovr_xfer_valid", 32'(valid), 32'd0);
        check("ovr_xfer_busy", 32'(busy), 32'd0);
        repeat (D + 10) tick();

        // reset while waiting for B discards the measurement
        do_reset();
        ready  = 1'b1;
        beat_a = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < D + 10) begin
            tick();
            n++;
        end
        check("wb_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_phase", 32'(phase_out), 32'd0);
        check("arst_period", 32'(period_out), 32'd0);
        check("arst_ovr", 32'(overrun), 32'd0);
        beat_a = 1'b0;
        repeat (2) tick();
        rst_n     = 1'b1;
        since_rst = 0;
        beat_b    = 1'b1;
        saw       = 1'b0;
        repeat (D + 40) begin
            tick();
            if (valid || busy) saw = 1'b1;
        end
        check("b_alone", 32'(saw), 32'd0);
        beat_b = 1'b0;
        repeat (D + 10) tick();

        // A tagged at 2^16-40, B 100 cycles later across the wrap
        do_reset();
        ready  = 1'b1;
        target = 65494 - D;
        while (since_rst < target) tick();
        beat_a = 1'b1;
        repeat (100) tick();
        beat_b = 1'b1;
        wait_valid(D + 20, "wrap");
        check("wrap_phase", 32'(phase_out), 32'd100);
        check("wrap_period", 32'(period_out), 32'd0);
        tick();
        check("wrap_drop", 32'(valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
